// File: rtl/bias_ram_loader_if.sv
// Stream-in / RAM-write-out bundle for the bias RAM loader.
// The slave side is the loader; the master side is the DMA stream source plus the RAM write port.
interface bias_ram_loader_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_BITS  = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [ADDR_BITS-1:0]  write_address;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output s_data, s_valid,
    input  s_ready, write_address, write_enable, write_data
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, write_address, write_enable, write_data
  );
endinterface

// File: rtl/bias_ram_loader.sv
// Streams N bias words into the RAM write port, zero-padding odd N to a full 256-bit row.
// Latency: one cycle from stream handshake to write strobe; stream stalls only on s_valid gaps, the RAM never back-pressures.
module bias_ram_loader #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   num_words,
  output logic                 busy,
  output logic                 done,
  bias_ram_loader_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_BITS:0] CAP = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic [ADDR_BITS:0]      n_words, n_words_nxt;
  logic [ADDR_BITS:0]      cnt, cnt_nxt;
  logic                    post_done;
  logic                    we_q, we_nxt;
  logic [ADDR_BITS-1:0]    wa_q, wa_nxt;
  logic [DATA_WIDTH-1:0]   wd_q, wd_nxt;
  logic [ADDR_BITS:0]      n_start;
  logic                    accept;
  logic                    last_word;

  assign n_start   = (num_words > CAP) ? CAP : num_words;
  assign accept    = bus.s_valid && (state == LOAD);
  assign last_word = (cnt == (n_words - ONE));

  always_comb begin
    state_nxt   = state;
    n_words_nxt = n_words;
    cnt_nxt     = cnt;
    we_nxt      = 1'b0;
    wa_nxt      = wa_q;
    wd_nxt      = wd_q;
    case (state)
      IDLE: begin
        // post_done marks the IDLE cycle that still counts as busy, so start is ignored there
        if (start && !post_done) begin
          n_words_nxt = n_start;
          cnt_nxt     = '0;
          state_nxt   = (n_start == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          we_nxt = 1'b1;
          wa_nxt = cnt[ADDR_BITS-1:0];
          wd_nxt = bus.s_data;
          if (last_word) begin
            state_nxt = n_words[0] ? PAD : DONE;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      PAD: begin
        we_nxt    = 1'b1;
        wa_nxt    = n_words[ADDR_BITS-1:0];
        wd_nxt    = '0;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_words   <= '0;
      cnt       <= '0;
      post_done <= 1'b0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else begin
      state     <= state_nxt;
      n_words   <= n_words_nxt;
      cnt       <= cnt_nxt;
      post_done <= (state == DONE);
      we_q      <= we_nxt;
      wa_q      <= wa_nxt;
      wd_q      <= wd_nxt;
    end
  end

  assign bus.s_ready       = (state == LOAD);
  assign bus.write_enable  = we_q;
  assign bus.write_address = wa_q;
  assign bus.write_data    = wd_q;
  assign done              = (state == DONE);
  assign busy              = (state != IDLE) || post_done;

endmodule
